uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte-wide UART transmitter (8N1, LSB first) fed by a small synchronous FIFO.
// Frames run back-to-back while the FIFO has data; each frame is 10*CLK_DIV cycles.
module uart_tx_fifo #(
   parameter int CLK_DIV    = 868,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           din,
   input  logic                  we,
   output logic                  txd,
   output logic                  busy,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overflow
);
   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam int LVL_W = DEPTH_LOG2 + 1;
   localparam int CNT_W = $clog2(CLK_DIV);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [2:0]             bit_idx_reg, bit_idx_next;
   logic [7:0]             shift_reg, shift_next;
   logic                   txd_reg, txd_next;
   logic                   bit_end;
   logic                   pop;

   logic [7:0]             mem [DEPTH];
   logic [DEPTH_LOG2-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [LVL_W-1:0]       level_reg, level_next;
   logic                   full_reg, empty_reg, overflow_reg;
   logic                   push;

   // Only the low byte of the write word is transmitted.
   logic unused_din_hi;
   assign unused_din_hi = ^din[31:8];

   assign push    = we && !full_reg;
   assign bit_end = (cnt_reg == CNT_W'(CLK_DIV - 1));

   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + LVL_W'(1);
         2'b01:   level_next = level_reg - LVL_W'(1);
         default: level_next = level_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset && push) begin
         mem[wr_ptr_reg] <= din[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         full_reg     <= 1'b0;
         empty_reg    <= 1'b1;
         overflow_reg <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
         // A write against a full FIFO is lost even if a pop frees a slot on the same edge.
         if (we && full_reg) overflow_reg <= 1'b1;
         level_reg <= level_next;
         full_reg  <= (level_next == LVL_W'(DEPTH));
         empty_reg <= (level_next == '0);
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      txd_next     = txd_reg;
      pop          = 1'b0;
      case (state_reg)
         IDLE: begin
            txd_next = 1'b1;
            cnt_next = '0;
            if (!empty_reg) begin
               pop        = 1'b1;
               shift_next = mem[rd_ptr_reg];
               state_next = START;
               txd_next   = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_next     = '0;
               bit_idx_next = 3'd0;
               state_next   = DATA;
               txd_next     = shift_reg[0];
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_next = '0;
               if (bit_idx_reg == 3'd7) begin
                  state_next = STOP;
                  txd_next   = 1'b1;
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
                  shift_next   = {1'b0, shift_reg[7:1]};
                  txd_next     = shift_reg[1];
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_next = '0;
               // Chain straight into the next start bit so frames have no idle gap.
               if (!empty_reg) begin
                  pop        = 1'b1;
                  shift_next = mem[rd_ptr_reg];
                  state_next = START;
                  txd_next   = 1'b0;
               end else begin
                  state_next = IDLE;
                  txd_next   = 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            txd_next   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         bit_idx_reg <= 3'd0;
         shift_reg   <= 8'd0;
         txd_reg     <= 1'b1;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         bit_idx_reg <= bit_idx_next;
         shift_reg   <= shift_next;
         txd_reg     <= txd_next;
      end
   end

   assign txd      = txd_reg;
   assign busy     = (state_reg != IDLE) || !empty_reg;
   assign full     = full_reg;
   assign empty    = empty_reg;
   assign level    = level_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (16-deep and 4-deep, CLK_DIV=4) with
// serial-line monitors that decode frames and check them against a byte scoreboard.
module tb_uart_tx_fifo;
   logic        clk;
   logic        rst_a, rst_b;
   logic [31:0] din_a, din_b;
   logic        we_a, we_b;
   logic        txd_a, busy_a, full_a, empty_a, overflow_a;
   logic        txd_b, busy_b, full_b, empty_b, overflow_b;
   logic [4:0]  level_a;
   logic [2:0]  level_b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   logic       txd_w  [2];
   logic       busy_w [2];
   bit         abort  [2];
   int         frame_cnt  [2];
   int         last_start [2];
   int         prev_start [2];

   uart_tx_fifo #(.CLK_DIV(4), .DEPTH_LOG2(4)) u_dut_a (
      .clk(clk), .reset(rst_a), .din(din_a), .we(we_a), .txd(txd_a), .busy(busy_a),
      .full(full_a), .empty(empty_a), .level(level_a), .overflow(overflow_a));

   uart_tx_fifo #(.CLK_DIV(4), .DEPTH_LOG2(2)) u_dut_b (
      .clk(clk), .reset(rst_b), .din(din_b), .we(we_b), .txd(txd_b), .busy(busy_b),
      .full(full_b), .empty(empty_b), .level(level_b), .overflow(overflow_b));

   assign txd_w[0]  = txd_a;
   assign txd_w[1]  = txd_b;
   assign busy_w[0] = busy_a;
   assign busy_w[1] = busy_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Decodes one frame per falling edge on txd, sampling mid-bit on negedges.
   task automatic monitor(input int idx);
      logic [7:0] data;
      logic       start_bit, stop_bit;
      logic [7:0] e;
      bit         ok, has;
      forever begin
         @(negedge clk);
         abort[idx] = 1'b0;
         if (txd_w[idx] == 1'b0) begin
            prev_start[idx] = last_start[idx];
            last_start[idx] = cyc;
            ok = 1'b1;
            data = 8'h00;
            start_bit = 1'b1;
            stop_bit = 1'b0;
            for (int s = 0; s < 38 && ok; s++) begin
               @(negedge clk);
               if (abort[idx]) ok = 1'b0;
               else if (s == 1) start_bit = txd_w[idx];
               else if (s >= 5 && s <= 33 && ((s - 5) % 4) == 0) data[(s - 5) / 4] = txd_w[idx];
               else if (s == 37) stop_bit = txd_w[idx];
            end
            if (ok) begin
               frame_cnt[idx]++;
               check($sformatf("frame_bits_%0d", idx), {start_bit, stop_bit}, 2'b01);
               has = 1'b0;
               e = 8'h00;
               if (idx == 0 && exp_a.size() > 0) begin has = 1'b1; e = exp_a.pop_front(); end
               if (idx == 1 && exp_b.size() > 0) begin has = 1'b1; e = exp_b.pop_front(); end
               checks++;
               if (!has) begin
                  errors++;
                  $display("FAIL unexpected_frame_%0d: got byte 0x%02h, expected no frame", idx, data);
               end else if (data !== e) begin
                  errors++;
                  $display("FAIL frame_data_%0d: got 0x%02h, expected 0x%02h", idx, data, e);
               end
            end
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   task automatic wait_idle(input int idx, input int max_cyc);
      int n = 0;
      while (busy_w[idx] && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("drain_bounded_%0d", idx), busy_w[idx], 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, f0, f1;
      rst_a = 1'b1; rst_b = 1'b1; we_a = 1'b0; we_b = 1'b0; din_a = '0; din_b = '0;
      for (int i = 0; i < 2; i++) begin
         abort[i] = 1'b0; frame_cnt[i] = 0; last_start[i] = 0; prev_start[i] = 0;
      end
      repeat (3) @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      check("rst_txd_a", txd_a, 1);
      check("rst_level_a", level_a, 0);
      check("rst_empty_a", empty_a, 1);
      check("rst_full_a", full_a, 0);
      check("rst_overflow_a", overflow_a, 0);
      check("rst_busy_a", busy_a, 0);
      check("rst_txd_b", txd_b, 1);
      check("rst_busy_b", busy_b, 0);

      // Single byte 0x55: txd falls two negedges after we is driven, busy lasts 40 cycles.
      din_a = 32'h0000_0055; we_a = 1'b1; exp_a.push_back(8'h55);
      @(negedge clk);
      we_a = 1'b0;
      check("t1_level", level_a, 1);
      check("t1_empty", empty_a, 0);
      check("t1_busy", busy_a, 1);
      check("t1_txd_still_idle", txd_a, 1);
      @(negedge clk);
      check("t1_txd_fall", txd_a, 0);
      check("t1_level_after_pop", level_a, 0);
      n = 0;
      while (busy_a && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t1_busy_len", n, 40);

      // Two bytes on consecutive cycles: contiguous frames, upper din bits ignored.
      f0 = frame_cnt[0];
      din_a = 32'hFFFF_FF41; we_a = 1'b1; exp_a.push_back(8'h41);
      @(negedge clk);
      din_a = 32'h0000_0042; exp_a.push_back(8'h42);
      @(negedge clk);
      we_a = 1'b0;
      wait_idle(0, 300);
      check("t2_frames", frame_cnt[0] - f0, 2);
      check("t2_back_to_back", last_start[0] - prev_start[0], 40);

      // Twenty paced bytes: pointers wrap, every byte arrives in order.
      f0 = frame_cnt[0];
      for (int i = 0; i < 20; i++) begin
         din_a = {24'hABCDEF, 8'(i * 37 + 3)}; we_a = 1'b1; exp_a.push_back(8'(i * 37 + 3));
         @(negedge clk);
         we_a = 1'b0;
         repeat (9) @(negedge clk);
      end
      wait_idle(0, 1200);
      check("t3_frames", frame_cnt[0] - f0, 20);
      check("t3_no_overflow", overflow_a, 0);
      check("t3_sb_empty", exp_a.size(), 0);

      // Depth-4 instance: six writes, first popped, four stored, sixth dropped.
      f1 = frame_cnt[1];
      for (int i = 0; i < 6; i++) begin
         din_b = 32'hA0 + i; we_b = 1'b1;
         if (i < 5) exp_b.push_back(8'(8'hA0 + i));
         @(negedge clk);
      end
      we_b = 1'b0;
      check("t4_full", full_b, 1);
      check("t4_overflow", overflow_b, 1);
      check("t4_level", level_b, 4);
      wait_idle(1, 400);
      check("t4_frames", frame_cnt[1] - f1, 5);
      check("t4_overflow_sticky", overflow_b, 1);
      check("t4_sb_empty", exp_b.size(), 0);

      // Write into a full FIFO on the edge the FSM pops: dropped, level 4 -> 3.
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      check("t5_overflow_cleared", overflow_b, 0);
      for (int i = 0; i < 5; i++) begin
         din_b = 32'hB0 + i; we_b = 1'b1; exp_b.push_back(8'(8'hB0 + i));
         @(negedge clk);
      end
      we_b = 1'b0;
      repeat (36) @(negedge clk);
      check("t5_full_before", full_b, 1);
      check("t5_level_before", level_b, 4);
      din_b = 32'h0000_00EE; we_b = 1'b1;
      @(negedge clk);
      we_b = 1'b0;
      check("t5_overflow", overflow_b, 1);
      check("t5_level_after", level_b, 3);
      check("t5_full_after", full_b, 0);

      // Reset during data bit 3 with three bytes queued; a same-edge write is ignored.
      repeat (16) @(negedge clk);
      f1 = frame_cnt[1];
      rst_b = 1'b1; abort[1] = 1'b1; exp_b.delete();
      din_b = 32'h0000_0077; we_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0; we_b = 1'b0;
      check("t6_txd", txd_b, 1);
      check("t6_level", level_b, 0);
      check("t6_empty", empty_b, 1);
      check("t6_overflow", overflow_b, 0);
      check("t6_busy", busy_b, 0);
      repeat (200) @(negedge clk);
      check("t6_no_frames", frame_cnt[1] - f1, 0);
      check("t6_still_idle", busy_b, 0);

      check("end_sb_a", exp_a.size(), 0);
      check("end_sb_b", exp_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
